// File: rtl/soc_oci_dct_pkg.sv
// Shared constants and types for the OCI trace DCT packer: branch codes,
// packed-word geometry and the end-of-trace FSM states.
package soc_oci_dct_pkg;

    localparam logic [1:0] DCT_NT  = 2'b00;
    localparam logic [1:0] DCT_TK  = 2'b01;
    localparam logic [1:0] DCT_IND = 2'b10;

    localparam int DCT_DEPTH = 15;
    localparam int DCT_W     = 30;
    localparam int DCT_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } dct_state_e;

endpackage

// File: rtl/soc_oci_dct_packer_outreg.sv
// One-entry valid/ready holding register for a packed DCT word and its count.
// A load is taken when the register is empty or hands off in the same cycle.
module soc_oci_dct_outreg
    import soc_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_valid,
    input  logic [DCT_W-1:0]     load_data,
    input  logic [DCT_CNT_W-1:0] load_cnt,
    output logic                 load_ready,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DCT_W-1:0]     dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count
);

    logic                 valid_q, valid_d;
    logic [DCT_W-1:0]     data_q, data_d;
    logic [DCT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        load_ready = !valid_q || out_ready;
        valid_d    = valid_q && !out_ready;
        data_d     = data_q;
        cnt_d      = cnt_q;
        if (load_valid && load_ready) begin
            valid_d = 1'b1;
            data_d  = load_data;
            cnt_d   = load_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign dct_buffer = data_q;
    assign dct_count  = cnt_q;

endmodule

// File: rtl/soc_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit branch codes into 15-entry words for the OCI trace sink and
// sequences end of trace. Define SOC_OCI_DCT_DROP_CNT_EN to add drop_count.
module soc_nios2_qsys_0_oci_dct_packer
    import soc_oci_dct_pkg::*;
#(
    parameter int ENTRY_W = 2,
    parameter int DEPTH   = 15,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       trc_on,
    input  logic                       br_valid,
    input  logic [ENTRY_W-1:0]         br_code,
    input  logic                       flush_req,
    input  logic                       end_req,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [ENTRY_W*DEPTH-1:0]   dct_buffer,
    output logic [CNT_W-1:0]           dct_count,
    output logic                       test_ending,
    output logic                       test_has_ended
`ifdef SOC_OCI_DCT_DROP_CNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    localparam int ACC_W = ENTRY_W * DEPTH;

    dct_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, merged_acc;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d, merged_cnt;
    logic               flush_pend_q, flush_pend_d;
    logic               entry_v, flush_v, acc_full;
    logic               emit_want, emit_fire, load_ready, ovld_next;

    always_comb begin
        entry_v  = (state_q == RUN) && trc_on && br_valid;
        flush_v  = (state_q == RUN) && flush_req;
        acc_full = (acc_cnt_q == CNT_W'(DEPTH));

        // A full accumulator cannot take the new entry into the current word
        if (acc_full || !entry_v) begin
            merged_acc = acc_q;
            merged_cnt = acc_cnt_q;
        end else begin
            merged_acc = {acc_q[ACC_W-ENTRY_W-1:0], br_code};
            merged_cnt = acc_cnt_q + CNT_W'(1);
        end

        emit_want = (merged_cnt == CNT_W'(DEPTH))
                 || ((flush_v || flush_pend_q) && (merged_cnt != '0))
                 || ((state_q == DRAIN) && (merged_cnt != '0));
        emit_fire = emit_want && load_ready;

        if (emit_fire) begin
            if (acc_full && entry_v) begin
                acc_d        = ACC_W'(br_code);
                acc_cnt_d    = CNT_W'(1);
                flush_pend_d = flush_v;
            end else begin
                acc_d        = '0;
                acc_cnt_d    = '0;
                flush_pend_d = 1'b0;
            end
        end else begin
            acc_d        = merged_acc;
            acc_cnt_d    = merged_cnt;
            flush_pend_d = flush_pend_q || (flush_v && (merged_cnt != '0));
        end

        ovld_next = emit_fire || (out_valid && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Leave for ENDED as soon as nothing will be buffered after this edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (end_req)
                    state_d = (acc_cnt_d == '0 && !ovld_next) ? ENDED : DRAIN;
            end
            DRAIN: begin
                if (acc_cnt_d == '0 && !ovld_next) state_d = ENDED;
            end
            ENDED:   state_d = ENDED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        test_ending    = (state_q != RUN);
        test_has_ended = (state_q == ENDED);
    end

    soc_oci_dct_outreg u_outreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (emit_want),
        .load_data  (merged_acc),
        .load_cnt   (merged_cnt),
        .load_ready (load_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count)
    );

`ifdef SOC_OCI_DCT_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop         = acc_full && entry_v && !load_ready;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF))
            drop_count_d = drop_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) drop_count_q <= '0;
        else          drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_soc_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the OCI DCT packer: packing, flush, backpressure/drop,
// end of trace and reset mid-operation, checked with immediate assertions.
module tb_soc_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n, trc_on, br_valid, flush_req, end_req, out_ready;
    logic [1:0]  br_code;
    logic        out_valid, test_ending, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
`ifdef SOC_OCI_DCT_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    soc_nios2_qsys_0_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trc_on         (trc_on),
        .br_valid       (br_valid),
        .br_code        (br_code),
        .flush_req      (flush_req),
        .end_req        (end_req),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
`ifdef SOC_OCI_DCT_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] code);
        br_valid = 1'b1;
        br_code  = code;
        tick();
        br_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [29:0] buf_exp, input logic [3:0] cnt_exp);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_count"}, {28'd0, dct_count}, {28'd0, cnt_exp});
        check({tag, "_buffer"}, {2'd0, dct_buffer}, {2'd0, buf_exp});
    endtask

    initial begin
        reset_n = 1'b0; trc_on = 1'b1; br_valid = 1'b0; br_code = 2'b00;
        flush_req = 1'b0; end_req = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_buffer", {2'd0, dct_buffer}, 32'd0);
        check("rst_count", {28'd0, dct_count}, 32'd0);
        check("rst_ending", {31'd0, test_ending}, 32'd0);
        check("rst_ended", {31'd0, test_has_ended}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Full packing: 01,00 alternating, oldest in bits 29:28
        for (int i = 0; i < 15; i++) begin
            push((i % 2 == 0) ? 2'b01 : 2'b00);
            if (i == 13) check("full_early", {31'd0, out_valid}, 32'd0);
        end
        check_word("full", 30'h11111111, 4'd15);
        tick();
        check("full_one_cycle", {31'd0, out_valid}, 32'd0);

        // Partial flush with an entry arriving alongside the flush
        push(2'b01); push(2'b01); push(2'b00);
        check("flush_pre", {31'd0, out_valid}, 32'd0);
        flush_req = 1'b1;
        push(2'b01);
        flush_req = 1'b0;
        check_word("flush", 30'h51, 4'd4);
        tick();
        check("flush_done", {31'd0, out_valid}, 32'd0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        check("flush_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure: two full words, then two dropped entries
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) push(2'b01);
        check_word("bp_first", 30'h15555555, 4'd15);
        push(2'b00); push(2'b00);
        check_word("bp_hold", 30'h15555555, 4'd15);
`ifdef SOC_OCI_DCT_DROP_CNT_EN
        check("bp_drop_count", {16'd0, drop_count}, 32'd2);
`endif
        out_ready = 1'b1;
        tick();
        check_word("bp_second", 30'h15555555, 4'd15);
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        flush_req = 1'b1;
        push(2'b10);
        flush_req = 1'b0;
        check_word("bp_clean_acc", 30'h2, 4'd1);
        tick();

        // End of test: 5 entries, end pulse, drain, ignore later input
        push(2'b01); push(2'b00); push(2'b10); push(2'b01); push(2'b11);
        end_req = 1'b1;
        tick();
        end_req = 1'b0;
        check("end_ending", {31'd0, test_ending}, 32'd1);
        check("end_not_ended", {31'd0, test_has_ended}, 32'd0);
        check("end_no_word_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check_word("end_word", 30'h127, 4'd5);
        check("end_not_ended2", {31'd0, test_has_ended}, 32'd0);
        tick();
        check("end_ended", {31'd0, test_has_ended}, 32'd1);
        check("end_ending_hold", {31'd0, test_ending}, 32'd1);
        check("end_valid_low", {31'd0, out_valid}, 32'd0);
        flush_req = 1'b1;
        for (int i = 0; i < 16; i++) push(2'b01);
        flush_req = 1'b0;
        tick();
        check("end_ignore_br", {31'd0, out_valid}, 32'd0);
        check("end_sticky", {31'd0, test_has_ended}, 32'd1);

        // Reset mid-operation with a held word and a partial accumulator
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) push(2'b10);
        for (int i = 0; i < 7; i++) push(2'b11);
        check_word("mid_held", 30'h2AAAAAAA, 4'd15);
        reset_n = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_buffer", {2'd0, dct_buffer}, 32'd0);
        check("mid_rst_count", {28'd0, dct_count}, 32'd0);
        check("mid_rst_ending", {31'd0, test_ending}, 32'd0);
        check("mid_rst_ended", {31'd0, test_has_ended}, 32'd0);
`ifdef SOC_OCI_DCT_DROP_CNT_EN
        check("mid_rst_drop", {16'd0, drop_count}, 32'd0);
`endif
        reset_n = 1'b1;
        tick();
        check("mid_no_stale", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            push(2'b01);
            if (i == 13) check("mid_no_partial", {31'd0, out_valid}, 32'd0);
        end
        check_word("mid_clean", 30'h15555555, 4'd15);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
